flag_branch_unit: RTL and testbench

- Downstream consumer of the EX-stage saturating adder's zr/neg/ov outputs.
- Holds the architectural Z/N/V flag register and updates it per-flag under write enables.
- Resolves conditional branches against the flags. A branch issued in the same cycle as a flag-setting EX instruction sees that instruction's new flags.
- Produces a registered taken/target result for the fetch stage, plus a saturating taken-branch counter.

---
 rtl/flag_branch_unit_pkg.sv | 24 ++
 rtl/flag_branch_unit_cond_eval.sv | 33 +++
 rtl/flag_branch_unit.sv | 94 +++++++++
 tb/tb_flag_branch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/flag_branch_unit_pkg.sv
// Shared definitions for the flag register and branch-condition logic.
package flag_pkg;

    localparam int unsigned FLAG_W = 3;

    // Bit positions inside the packed {Z,N,V} flag vector
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 0;

    typedef logic [FLAG_W-1:0] flag_t;

    localparam int unsigned COND_W = 3;

    localparam logic [COND_W-1:0] COND_NEQ    = 3'b000;
    localparam logic [COND_W-1:0] COND_EQ     = 3'b001;
    localparam logic [COND_W-1:0] COND_GT     = 3'b010;
    localparam logic [COND_W-1:0] COND_LT     = 3'b011;
    localparam logic [COND_W-1:0] COND_GTE    = 3'b100;
    localparam logic [COND_W-1:0] COND_LTE    = 3'b101;
    localparam logic [COND_W-1:0] COND_OVFL   = 3'b110;
    localparam logic [COND_W-1:0] COND_UNCOND = 3'b111;

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational condition-code evaluator over a {Z,N,V} flag vector.
module cond_eval
    import flag_pkg::*;
(
    input  flag_t             flags,
    input  logic [COND_W-1:0] cond,
    output logic              taken_c
);

    logic w_z;
    logic w_n;
    logic w_v;

    assign w_z = flags[FLAG_Z];
    assign w_n = flags[FLAG_N];
    assign w_v = flags[FLAG_V];

    always_comb begin
        taken_c = 1'b0;
        case (cond)
            COND_NEQ:    taken_c = ~w_z;
            COND_EQ:     taken_c = w_z;
            COND_GT:     taken_c = ~w_z & ~w_n;
            COND_LT:     taken_c = w_n;
            COND_GTE:    taken_c = w_z | ~w_n;
            COND_LTE:    taken_c = w_z | w_n;
            COND_OVFL:   taken_c = w_v;
            COND_UNCOND: taken_c = 1'b1;
            default:     taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural Z/N/V flag register with same-cycle forwarding into branch resolution.
module flag_branch_unit
    import flag_pkg::*;
#(
    parameter int unsigned PC_W  = 16,
    parameter int unsigned OFF_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_zr,
    input  logic              ex_neg,
    input  logic              ex_ov,
    input  logic              ex_set_z,
    input  logic              ex_set_n,
    input  logic              ex_set_v,
    input  logic              br_valid,
    input  logic [COND_W-1:0] br_cond,
    input  logic [PC_W-1:0]   br_pc_plus1,
    input  logic [OFF_W-1:0]  br_offset,
    input  logic              stall,
    input  logic              flush,
    output flag_t             flags_q,
    output logic              br_resolved,
    output logic              br_taken,
    output logic [PC_W-1:0]   br_target,
    output logic [PC_W-1:0]   taken_cnt
);

    flag_t             r_flags;
    logic              r_resolved;
    logic              r_taken;
    logic [PC_W-1:0]   r_target;
    logic [PC_W-1:0]   r_taken_cnt;

    flag_t             w_flags_next;
    logic              w_cond_taken;
    logic [PC_W-1:0]   w_offset_sext;
    logic [PC_W-1:0]   w_target;
    logic              w_cnt_sat;

    // Forwarded flags: what the register will hold after this edge
    always_comb begin
        w_flags_next         = r_flags;
        if (ex_valid && ex_set_z) w_flags_next[FLAG_Z] = ex_zr;
        if (ex_valid && ex_set_n) w_flags_next[FLAG_N] = ex_neg;
        if (ex_valid && ex_set_v) w_flags_next[FLAG_V] = ex_ov;
    end

    cond_eval u_cond_eval (
        .flags   (w_flags_next),
        .cond    (br_cond),
        .taken_c (w_cond_taken)
    );

    // Target wraps modulo 2^PC_W; no saturation here
    assign w_offset_sext = {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
    assign w_target      = br_pc_plus1 + w_offset_sext;
    assign w_cnt_sat     = (r_taken_cnt == {PC_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags     <= '0;
            r_resolved  <= 1'b0;
            r_taken     <= 1'b0;
            r_target    <= '0;
            r_taken_cnt <= '0;
        end else if (flush) begin
            r_resolved  <= 1'b0;
            r_taken     <= 1'b0;
            r_target    <= '0;
        end else if (stall) begin
            // Drop the pulse so a held branch is not reported twice
            r_resolved  <= 1'b0;
        end else begin
            r_flags     <= w_flags_next;
            r_resolved  <= br_valid;
            r_taken     <= br_valid & w_cond_taken;
            if (br_valid) begin
                r_target <= w_target;
            end
            if (br_valid && w_cond_taken && !w_cnt_sat) begin
                r_taken_cnt <= r_taken_cnt + PC_W'(1);
            end
        end
    end

    assign flags_q     = r_flags;
    assign br_resolved = r_resolved;
    assign br_taken    = r_taken;
    assign br_target   = r_target;
    assign taken_cnt   = r_taken_cnt;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed and randomized bench for flag_branch_unit against a behavioural model.
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_zr, ex_neg, ex_ov;
    logic        ex_set_z, ex_set_n, ex_set_v;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [15:0] br_pc_plus1;
    logic [8:0]  br_offset;
    logic        stall, flush;
    logic [2:0]  flags_q;
    logic        br_resolved, br_taken;
    logic [15:0] br_target, taken_cnt;

    int total = 0;
    int bad   = 0;

    // Reference state
    bit m_z, m_n, m_v;
    bit m_res, m_tkn;
    int m_tgt;
    int m_cnt;

    always #5 clk = ~clk;

    flag_branch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_zr       (ex_zr),
        .ex_neg      (ex_neg),
        .ex_ov       (ex_ov),
        .ex_set_z    (ex_set_z),
        .ex_set_n    (ex_set_n),
        .ex_set_v    (ex_set_v),
        .br_valid    (br_valid),
        .br_cond     (br_cond),
        .br_pc_plus1 (br_pc_plus1),
        .br_offset   (br_offset),
        .stall       (stall),
        .flush       (flush),
        .flags_q     (flags_q),
        .br_resolved (br_resolved),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .taken_cnt   (taken_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cond_holds(input int code, input bit z, input bit n, input bit v);
        case (code)
            0: return !z;
            1: return z;
            2: return !z && !n;
            3: return n;
            4: return z || !n;
            5: return z || n;
            6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int target_of(input int pc, input int off9);
        int off;
        off = (off9 >= 256) ? off9 - 512 : off9;
        return (pc + off) & 'hFFFF;
    endfunction

    task automatic model_update();
        bit fz, fn, fv, t;
        if (rst) begin
            {m_z, m_n, m_v} = 3'b000;
            m_res = 0; m_tkn = 0; m_tgt = 0; m_cnt = 0;
        end else if (flush) begin
            m_res = 0; m_tkn = 0; m_tgt = 0;
        end else if (stall) begin
            m_res = 0;
        end else begin
            fz = (ex_valid && ex_set_z) ? ex_zr  : m_z;
            fn = (ex_valid && ex_set_n) ? ex_neg : m_n;
            fv = (ex_valid && ex_set_v) ? ex_ov  : m_v;
            t  = cond_holds(int'(br_cond), fz, fn, fv);
            m_z = fz; m_n = fn; m_v = fv;
            m_res = br_valid;
            m_tkn = br_valid && t;
            if (br_valid) m_tgt = target_of(int'(br_pc_plus1), int'(br_offset));
            if (br_valid && t && m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic check_all();
        check_eq("flags", 32'(flags_q), 32'({m_z, m_n, m_v}));
        check_eq("resolved", 32'(br_resolved), 32'(m_res));
        check_eq("taken", 32'(br_taken), 32'(m_tkn));
        check_eq("target", 32'(br_target), 32'(m_tgt));
        check_eq("cnt", 32'(taken_cnt), 32'(m_cnt));
    endtask

    task automatic step(input bit do_chk);
        model_update();
        @(posedge clk);
        #1;
        if (do_chk) check_all();
    endtask

    task automatic idle();
        rst = 0; ex_valid = 0; ex_zr = 0; ex_neg = 0; ex_ov = 0;
        ex_set_z = 0; ex_set_n = 0; ex_set_v = 0;
        br_valid = 0; br_cond = 0; br_pc_plus1 = 0; br_offset = 0;
        stall = 0; flush = 0;
    endtask

    task automatic randomize_inputs();
        rst      = ($urandom_range(0, 49) == 0);
        flush    = ($urandom_range(0, 9) == 0);
        stall    = ($urandom_range(0, 4) == 0);
        ex_valid = 1'($urandom_range(0, 1));
        ex_zr    = 1'($urandom_range(0, 1));
        ex_neg   = 1'($urandom_range(0, 1));
        ex_ov    = 1'($urandom_range(0, 1));
        ex_set_z = 1'($urandom_range(0, 1));
        ex_set_n = 1'($urandom_range(0, 1));
        ex_set_v = 1'($urandom_range(0, 1));
        br_valid = ($urandom_range(0, 3) != 0);
        br_cond  = 3'($urandom_range(0, 7));
        br_pc_plus1 = 16'($urandom);
        br_offset   = 9'($urandom);
    endtask

    initial begin
        int pulses;

        // Reset with every input active
        idle();
        rst = 1; ex_valid = 1; ex_zr = 1; ex_neg = 1; ex_ov = 1;
        ex_set_z = 1; ex_set_n = 1; ex_set_v = 1;
        br_valid = 1; br_cond = 3'b111; br_pc_plus1 = 16'h1234; br_offset = 9'h005;
        stall = 1; flush = 1;
        step(1'b0);
        step(1'b0);
        check_eq("rst_flags", 32'(flags_q), 32'h0);
        check_eq("rst_resolved", 32'(br_resolved), 32'h0);
        check_eq("rst_cnt", 32'(taken_cnt), 32'h0);
        check_all();

        // Flag write forwarded into EQ branch
        idle();
        ex_valid = 1; ex_zr = 1; ex_set_z = 1; ex_set_n = 1; ex_set_v = 1;
        br_valid = 1; br_cond = 3'b001; br_pc_plus1 = 16'h0010; br_offset = 9'h1FD;
        step(1'b1);
        check_eq("fwd_resolved", 32'(br_resolved), 32'h1);
        check_eq("fwd_taken", 32'(br_taken), 32'h1);
        check_eq("fwd_target", 32'(br_target), 32'h000D);
        check_eq("fwd_flags", 32'(flags_q), 32'h4);
        check_eq("fwd_cnt", 32'(taken_cnt), 32'h1);

        // Partial write: only V, branch GT not taken
        idle();
        ex_valid = 1; ex_set_v = 1; ex_ov = 1; ex_zr = 0; ex_neg = 1;
        br_valid = 1; br_cond = 3'b010; br_pc_plus1 = 16'h0100; br_offset = 9'h004;
        step(1'b1);
        check_eq("gt_taken", 32'(br_taken), 32'h0);
        check_eq("gt_flags", 32'(flags_q), 32'h5);

        // Target wrap-around
        idle();
        br_valid = 1; br_cond = 3'b111; br_pc_plus1 = 16'hFFFF; br_offset = 9'h001;
        step(1'b1);
        check_eq("wrap_target", 32'(br_target), 32'h0000);
        check_eq("wrap_taken", 32'(br_taken), 32'h1);

        // Branch held by stall, then re-presented
        pulses = 0;
        idle();
        br_valid = 1; br_cond = 3'b111; br_pc_plus1 = 16'h0200; br_offset = 9'h010;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            if (br_resolved) pulses++;
        end
        stall = 0;
        step(1'b1);
        check_eq("stall_release_pulse", 32'(br_resolved), 32'h1);
        if (br_resolved) pulses++;
        idle();
        step(1'b1);
        if (br_resolved) pulses++;
        check_eq("stall_pulse_count", 32'(pulses), 32'h1);

        // Flush kills branch and flag write
        idle();
        flush = 1; ex_valid = 1; ex_set_z = 1; ex_set_n = 1; ex_set_v = 1;
        ex_zr = 0; ex_neg = 1; ex_ov = 0;
        br_valid = 1; br_cond = 3'b111; br_pc_plus1 = 16'h0300; br_offset = 9'h001;
        step(1'b1);
        check_eq("flush_resolved", 32'(br_resolved), 32'h0);
        check_eq("flush_flags", 32'(flags_q), 32'h5);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            randomize_inputs();
            step(1'b1);
        end

        // Drive counter up to FFFE with back-to-back taken branches
        idle();
        br_valid = 1; br_cond = 3'b111;
        while (m_cnt < 'hFFFE) begin
            br_pc_plus1 = 16'($urandom);
            step(1'b0);
        end
        check_all();
        check_eq("pre_sat_cnt", 32'(taken_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            check_eq("sat_cnt", 32'(taken_cnt), 32'hFFFF);
            check_eq("sat_pulse", 32'(br_resolved), 32'h1);
        end

        idle();
        step(1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
